mem_arbiter_2x1: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/mem_arb_route_fifo.sv | 54 +++++
 rtl/mem_arbiter_2x1.sv | 113 +++++++++++
 tb/tb_mem_arbiter_2x1.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, width helpers and grant selection for the 2:1 memory arbiter.
// Message layout: {op, opaque, addr, len, data}.
package mem_arb_pkg;

    typedef logic t_client_id;

    localparam t_client_id CLIENT_FETCH = 1'b0;
    localparam t_client_id CLIENT_LSU   = 1'b1;

    function automatic int len_width(input int data_bits);
        return $clog2(data_bits / 8);
    endfunction

    function automatic int msg_width(input int opaq_bits, input int addr_bits, input int data_bits);
        return 1 + opaq_bits + addr_bits + len_width(data_bits) + data_bits;
    endfunction

    localparam int LEN_W = len_width(32);
    localparam int REQ_W = msg_width(8, 32, 32);

    // A lone valid client always wins; a tie goes to the other client than last
    // time under round-robin, otherwise to the LSU.
    function automatic t_client_id select_grant(
        input logic       v0,
        input logic       v1,
        input logic       rr_en,
        input t_client_id rr_last
    );
        t_client_id g;
        if (v0 && v1) begin
            g = rr_en ? ~rr_last : CLIENT_LSU;
        end else if (v1) begin
            g = CLIENT_LSU;
        end else begin
            g = CLIENT_FETCH;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arb_route_fifo.sv
// In-order FIFO of client IDs, one entry per outstanding memory request.
// Depth must be a power of two so the pointers wrap without extra logic.
module mem_arb_route_fifo
    import mem_arb_pkg::*;
#(
    parameter int p_depth = 4,
    localparam int ptr_w = $clog2(p_depth),
    localparam int cnt_w = ptr_w + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  t_client_id push_id,
    input  logic       pop,
    output t_client_id head,
    output logic       full,
    output logic       empty
);

    t_client_id       slots [p_depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == cnt_w'(p_depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ptr_w'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ptr_w'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot contents are only meaningful between push and pop, so they skip reset.
    always_ff @(posedge clk) begin
        if (push_ok) slots[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_arbiter_2x1.sv
// Two-client (fetch, LSU) arbiter onto one in-order memory port, responses
// steered back by a route FIFO. Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_arbiter_2x1
    import mem_arb_pkg::*;
#(
    parameter int p_addr_bits     = 32,
    parameter int p_data_bits     = 32,
    parameter int p_opaq_bits     = 8,
    parameter int p_max_in_flight = 4,
    localparam int msg_w = msg_width(p_opaq_bits, p_addr_bits, p_data_bits)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [msg_w-1:0] req0_msg,
    output logic             resp0_val,
    input  logic             resp0_rdy,
    output logic [msg_w-1:0] resp0_msg,

    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [msg_w-1:0] req1_msg,
    output logic             resp1_val,
    input  logic             resp1_rdy,
    output logic [msg_w-1:0] resp1_msg,

    output logic             mem_req_val,
    input  logic             mem_req_rdy,
    output logic [msg_w-1:0] mem_req_msg,
    input  logic             mem_resp_val,
    output logic             mem_resp_rdy,
    input  logic [msg_w-1:0] mem_resp_msg,

    output logic             err
);

    t_client_id grant;
    t_client_id head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    t_client_id rr_last;

    // Starting at LSU means fetch wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= CLIENT_LSU;
        end else if (push) begin
            rr_last <= grant;
        end
    end

    assign grant = select_grant(req0_val, req1_val, 1'b1, rr_last);
`else
    assign grant = select_grant(req0_val, req1_val, 1'b0, CLIENT_LSU);
`endif

    // Request path: purely combinational, no added latency.
    assign mem_req_val = (req0_val || req1_val) && !full;
    assign mem_req_msg = (grant == CLIENT_LSU) ? req1_msg : req0_msg;
    assign req0_rdy    = mem_req_val && mem_req_rdy && (grant == CLIENT_FETCH);
    assign req1_rdy    = mem_req_val && mem_req_rdy && (grant == CLIENT_LSU);
    assign push        = mem_req_val && mem_req_rdy;

    // Response path: the FIFO head owns the memory response; with nothing
    // outstanding, stray responses are swallowed and flagged.
    assign resp0_msg = mem_resp_msg;
    assign resp1_msg = mem_resp_msg;

    always_comb begin
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        mem_resp_rdy = 1'b1;
        if (!empty) begin
            if (head == CLIENT_LSU) begin
                resp1_val    = mem_resp_val;
                mem_resp_rdy = resp1_rdy;
            end else begin
                resp0_val    = mem_resp_val;
                mem_resp_rdy = resp0_rdy;
            end
        end
    end

    assign pop = mem_resp_val && mem_resp_rdy && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (empty && mem_resp_val) begin
            err <= 1'b1;
        end
    end

    mem_arb_route_fifo #(
        .p_depth (p_max_in_flight)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (grant),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Directed scoreboard bench for mem_arbiter_2x1; tie expectations follow
// MEM_ARB_ROUND_ROBIN_EN so the same bench covers both builds.
module tb_mem_arbiter_2x1;
    import mem_arb_pkg::*;

    localparam int W = REQ_W;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit rr_on = 1'b1;
`else
    localparam bit rr_on = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_val, req0_rdy, resp0_val, resp0_rdy;
    logic [W-1:0] req0_msg, resp0_msg;
    logic         req1_val, req1_rdy, resp1_val, resp1_rdy;
    logic [W-1:0] req1_msg, resp1_msg;
    logic         mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic [W-1:0] mem_req_msg, mem_resp_msg;
    logic         err;

    always #5 clk = ~clk;

    mem_arbiter_2x1 dut (
        .clk          (clk),
        .rst          (rst),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req0_msg     (req0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp0_msg    (resp0_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .req1_msg     (req1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .resp1_msg    (resp1_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .mem_resp_msg (mem_resp_msg),
        .err          (err)
    );

    typedef struct packed {
        logic         id;
        logic [W-1:0] msg;
    } sb_ent_t;

    sb_ent_t sb[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    function automatic logic [W-1:0] mk(input logic op, input logic [7:0] opq,
                                        input logic [31:0] addr, input logic [31:0] data);
        return {op, opq, addr, 2'd2, data};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock of stimulus. Request-side expectations come from the caller;
    // response-side expectations come from the scoreboard head. Memory echoes
    // the request message it received back as the response.
    task automatic step(input logic v0, input logic [W-1:0] m0,
                        input logic v1, input logic [W-1:0] m1,
                        input logic mrdy, input logic exp_mval, input logic exp_gnt,
                        input logic rv, input logic r0, input logic r1);
        logic [W-1:0] rmsg;
        logic         h;
        logic         hrdy;
        logic         pop_now;
        sb_ent_t      e;
        req0_val     = v0;
        req0_msg     = m0;
        req1_val     = v1;
        req1_msg     = m1;
        mem_req_rdy  = mrdy;
        resp0_rdy    = r0;
        resp1_rdy    = r1;
        mem_resp_val = rv;
        rmsg         = (sb.size() > 0) ? sb[0].msg : mk(1'b1, 8'hEE, 32'hDEAD_BEEF, 32'h5A5A_5A5A);
        mem_resp_msg = rmsg;
        @(negedge clk);
        check("mem_req_val", 128'(mem_req_val), 128'(exp_mval));
        check("req0_rdy", 128'(req0_rdy), 128'(exp_mval && mrdy && !exp_gnt));
        check("req1_rdy", 128'(req1_rdy), 128'(exp_mval && mrdy && exp_gnt));
        if (exp_mval) check("mem_req_msg", 128'(mem_req_msg), 128'(exp_gnt ? m1 : m0));
        pop_now = 1'b0;
        if (sb.size() > 0) begin
            h    = sb[0].id;
            hrdy = h ? r1 : r0;
            check("resp0_val", 128'(resp0_val), 128'(rv && !h));
            check("resp1_val", 128'(resp1_val), 128'(rv && h));
            check("mem_resp_rdy", 128'(mem_resp_rdy), 128'(hrdy));
            if (rv) begin
                check("resp0_msg", 128'(resp0_msg), 128'(rmsg));
                check("resp1_msg", 128'(resp1_msg), 128'(rmsg));
            end
            pop_now = rv && hrdy;
        end else begin
            check("resp0_val_empty", 128'(resp0_val), 128'(0));
            check("resp1_val_empty", 128'(resp1_val), 128'(0));
            check("mem_resp_rdy_empty", 128'(mem_resp_rdy), 128'(1));
        end
        @(posedge clk);
        if (pop_now) void'(sb.pop_front());
        if (exp_mval && mrdy) begin
            e.id  = exp_gnt;
            e.msg = exp_gnt ? m1 : m0;
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && sb.size() > 0; k++)
            step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("drained", 128'(sb.size()), 128'(0));
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req0_val     = 1'b0;
        req1_val     = 1'b0;
        mem_resp_val = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst          = 1'b1;
        req0_val     = 1'b0;
        req0_msg     = '0;
        req1_val     = 1'b0;
        req1_msg     = '0;
        resp0_rdy    = 1'b1;
        resp1_rdy    = 1'b1;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        @(negedge clk);
        check("rst_mem_req_val", 128'(mem_req_val), 128'(0));
        check("rst_req0_rdy", 128'(req0_rdy), 128'(0));
        check("rst_req1_rdy", 128'(req1_rdy), 128'(0));
        check("rst_resp0_val", 128'(resp0_val), 128'(0));
        check("rst_resp1_val", 128'(resp1_val), 128'(0));
        check("rst_mem_resp_rdy", 128'(mem_resp_rdy), 128'(1));
        check("rst_err", 128'(err), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single client, three fetches then three echoed responses
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(1'b0, 8'(i + 1), 32'(i * 4), 32'h0), 1'b0, '0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // tie for four cycles
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, mk(1'b0, 8'h10 + 8'(i), 32'h100 + 32'(i), 32'h0),
                 1'b1, mk(1'b1, 8'h20 + 8'(i), 32'h200 + 32'(i), 32'hCAFE_0000 + 32'(i)),
                 1'b1, 1'b1, rr_on ? logic'(i % 2) : 1'b1, 1'b0, 1'b1, 1'b1);
        drain();

        // full: four accepted, then blocked until a response transfers
        for (int i = 0; i < 4; i++)
            step(1'b1, mk(1'b0, 8'h30 + 8'(i), 32'h300 + 32'(i * 4), 32'h0), 1'b0, '0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            step(1'b1, mk(1'b0, 8'h34, 32'h310, 32'h0), 1'b0, '0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, mk(1'b0, 8'h34, 32'h310, 32'h0), 1'b0, '0,
             1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("full_after_pop", 128'(sb.size()), 128'(3));
        step(1'b1, mk(1'b0, 8'h34, 32'h310, 32'h0), 1'b0, '0,
             1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // interleave 0,1,1,0 with LSU back-pressure on its first response
        step(1'b1, mk(1'b0, 8'h40, 32'h400, 32'h0), 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, mk(1'b1, 8'h41, 32'h404, 32'h1111), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, mk(1'b0, 8'h42, 32'h408, 32'h0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, mk(1'b0, 8'h43, 32'h40C, 32'h0), 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("bp_no_pop", 128'(sb.size()), 128'(3));
        drain();

        // simultaneous push and pop at count 2 across pointer wrap
        step(1'b1, mk(1'b0, 8'h50, 32'h500, 32'h0), 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, mk(1'b1, 8'h51, 32'h504, 32'h2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(i % 3 == 0, mk(1'b0, 8'h60 + 8'(i), 32'h600 + 32'(i * 4), 32'h0),
                 i % 3 != 0, mk(1'b1, 8'h70 + 8'(i), 32'h700 + 32'(i * 4), 32'(i)),
                 1'b1, 1'b1, logic'(i % 3 != 0), 1'b1, 1'b1, 1'b1);
            check("pushpop_count", 128'(dut.u_route_fifo.count), 128'(2));
        end
        drain();

        // stray response with nothing outstanding
        @(negedge clk);
        check("err_before_stray", 128'(err), 128'(0));
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("err_after_stray", 128'(err), 128'(1));
        idle();
        check("err_sticky", 128'(err), 128'(1));

        // reset in the middle of traffic
        step(1'b1, mk(1'b0, 8'h80, 32'h800, 32'h0), 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, mk(1'b1, 8'h81, 32'h804, 32'h3), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        do_reset();
        @(negedge clk);
        check("midrst_err", 128'(err), 128'(0));
        check("midrst_count", 128'(dut.u_route_fifo.count), 128'(0));
        check("midrst_mem_resp_rdy", 128'(mem_resp_rdy), 128'(1));
        @(posedge clk);
        #1;
        step(1'b1, mk(1'b0, 8'h90, 32'h900, 32'h0), 1'b1, mk(1'b1, 8'h91, 32'h904, 32'h4),
             1'b1, 1'b1, rr_on ? 1'b0 : 1'b1, 1'b0, 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
